cdr_frame_sync: RTL
===================

Name: cdr_frame_sync

Overview:
- Downstream consumer of the CDR core. It takes the recovered bit-decision stream (d_bb, qualified by sample_en) and deserialises it MSB-first.
- It hunts for a sync byte and verifies repeated sync occurrences at the frame period before declaring lock.
- Once locked, it emits aligned payload bytes with valid and frame-start strobes, and tracks sync loss.
- It sits between cdr_core and the top-level output mux.

Parameters:
- SYNC_WORD, 8'hD5, sync byte expected at the start of every frame.
- FRAME_BYTES, 4, payload bytes following each sync byte (range 1..255).
- LOCK_COUNT, 2, consecutive sync hits needed to enter LOCKED (range 1..15); includes the hunt hit.
- LOSS_COUNT, 2, consecutive sync misses in LOCKED that force a return to HUNT (range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sample_en  in  1  one-cycle strobe; d_bb is valid when high
- d_bb  in  1  recovered bit decision (1 = positive)
- byte_out  out  8  last completed payload byte, MSB = first received bit
- byte_valid  out  1  one-cycle pulse, byte_out updated
- frame_start  out  1  one-cycle pulse, coincident with byte_valid of payload byte 0
- locked  out  1  high while in LOCKED
- sync_state  out  2  00 HUNT, 01 VERIFY, 10 LOCKED
- miss_cnt_total  out  8  saturating count of sync misses seen while LOCKED

Behaviour:
- Reset: rst asynchronous, active-high; all registers clear immediately.
  - byte_out=0, byte_valid=0, frame_start=0, locked=0, sync_state=HUNT, miss_cnt_total=0.
  - Shift register, bit_cnt, byte_cnt, hit_cnt and miss_cnt all 0.
- Nothing advances on cycles with sample_en=0; strobes are low on those cycles.
- Shift: on sample_en, sr <= {sr[6:0], d_bb}. The candidate byte is cand = {sr[6:0], d_bb}, the byte including the current bit.
- HUNT:
  - On every sample_en, compare cand against SYNC_WORD.
  - On a match: bit_cnt=0, byte_cnt=0, hit_cnt=1. If LOCK_COUNT==1, go to LOCKED; otherwise go to VERIFY.
- Framing counters (VERIFY/LOCKED):
  - bit_cnt increments 0..7 on each sample_en.
  - On the sample_en with bit_cnt==7, bit_cnt wraps to 0 and byte_cnt advances 0..FRAME_BYTES, then wraps to 0.
  - byte_cnt==FRAME_BYTES marks the sync slot. Its completing sample_en is the check point.
- VERIFY, at the check point:
  - cand==SYNC_WORD: hit_cnt++. When hit_cnt reaches LOCK_COUNT, go to LOCKED with miss_cnt=0.
  - Otherwise: go to HUNT, hit_cnt=0.
  - No payload is emitted in VERIFY.
- LOCKED, payload slots (byte_cnt 0..FRAME_BYTES-1):
  - On the completing sample_en (bit_cnt==7), register byte_out=cand and pulse byte_valid the following cycle (latency 1 clk after the strobe).
  - frame_start pulses with it when byte_cnt==0.
- LOCKED, check point:
  - Hit: miss_cnt=0.
  - Miss: miss_cnt++ and miss_cnt_total++ (saturating at 255).
  - When miss_cnt reaches LOSS_COUNT: go to HUNT, locked=0 the next cycle, hit_cnt=0, miss_cnt=0.
  - On that transition, the first HUNT comparison uses the next sample_en; the current bit is not re-searched.
- Lock timing: locked rises the cycle after the check-point sample_en. The first payload byte emitted is the one following the locking sync byte.
- Overlap: while in VERIFY or LOCKED, a sync pattern appearing off-slot is ignored.
- Pipelining: back-to-back sample_en on consecutive clocks must be supported, one bit per clock.
- Mid-frame reset: all outputs clear asynchronously. After release, hunting restarts from an empty shift register; stale bits never match.
- locked and sync_state are registered with no glitches. byte_valid and frame_start are never asserted outside LOCKED, except on the cycle that exits LOCKED, where a pulse registered on the prior cycle may still complete.

Decomposition:
- Shared package cdr_pkg:
  - state encodings ST_HUNT/ST_VERIFY/ST_LOCKED.
  - default SYNC_WORD constant.
  - counter widths derived via $clog2(FRAME_BYTES+1) and $clog2(LOCK_COUNT+1).
- One natural sub-module, frame_counter: bit_cnt/byte_cnt with a sync-slot flag, load-to-zero on hunt match.
- The FSM, compare logic and output registers stay in cdr_frame_sync.

Test Plan:
- Stream 0xD5, 4 payload (0x11,0x22,0x33,0x44), 0xD5, 4 payload (0x55,0x66,0x77,0x88), one sample_en every 2 clk. Required: VERIFY after the first 0xD5, locked after the second, byte_valid exactly 4 times with 0x55,0x66,0x77,0x88, frame_start on 0x55 only.
- Same stream but the second sync is 0xD4. Required: VERIFY→HUNT at the check point, no byte_valid, locked stays 0.
- Lock, then corrupt two consecutive sync bytes. Required: locked stays 1 after the first miss (miss_cnt_total=1) and drops after the second (miss_cnt_total=2), with sync_state=HUNT.
- Lock, miss one sync, then a valid sync. Required: stays LOCKED, miss_cnt resets, payload of every frame emitted.
- Payload containing 0xD5 (0xD5,0xD5,0x00,0x00) while locked. Required: emitted as data; no realignment; frame_start only at true frame boundaries.
- Assert rst for 1 clk mid-payload while locked. Required: locked, byte_valid, byte_out and miss_cnt_total go to 0 asynchronously; relock only after LOCK_COUNT fresh sync hits.

Source files
------------

// File: rtl/cdr_pkg.sv
// Shared definitions for the CDR frame synchroniser: state encodings, default
// framing constants and the counter-width helper.
package cdr_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCKED = 2'b10
  } sync_state_e;

  localparam logic [7:0] DEF_SYNC_WORD   = 8'hD5;
  localparam int         DEF_FRAME_BYTES = 4;
  localparam int         DEF_LOCK_COUNT  = 2;
  localparam int         DEF_LOSS_COUNT  = 2;

  // Bits needed to hold every value 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cdr_frame_sync_frame_counter.sv
// Bit/byte position tracker for one frame: FRAME_BYTES payload slots followed
// by a single sync slot, restarted from zero when the hunter finds sync.
module frame_counter
  import cdr_pkg::*;
#(
  parameter int FRAME_BYTES = DEF_FRAME_BYTES,
  parameter int BYTE_W      = cnt_width(FRAME_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_adv,
  input  logic              i_load,
  output logic [BYTE_W-1:0] o_byte_cnt,
  output logic              o_byte_done,
  output logic              o_sync_slot
);

  localparam logic [BYTE_W-1:0] LAST_SLOT = BYTE_W'(FRAME_BYTES);

  logic [2:0]        r_bit_cnt;
  logic [BYTE_W-1:0] r_byte_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
    end else if (i_load) begin
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
    end else if (i_adv) begin
      if (r_bit_cnt == 3'd7) begin
        r_bit_cnt  <= '0;
        r_byte_cnt <= (r_byte_cnt == LAST_SLOT) ? '0 : r_byte_cnt + 1'b1;
      end else begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

  assign o_byte_cnt  = r_byte_cnt;
  assign o_byte_done = i_adv & (r_bit_cnt == 3'd7);
  assign o_sync_slot = (r_byte_cnt == LAST_SLOT);

endmodule

// File: rtl/cdr_frame_sync.sv
// Frame synchroniser behind the CDR: MSB-first deserialiser, sync hunt/verify/
// lock state machine, aligned payload output and sync-loss tracking.
module cdr_frame_sync
  import cdr_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD   = DEF_SYNC_WORD,
  parameter int         FRAME_BYTES = DEF_FRAME_BYTES,
  parameter int         LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int         LOSS_COUNT  = DEF_LOSS_COUNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic       d_bb,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       locked,
  output logic [1:0] sync_state,
  output logic [7:0] miss_cnt_total
);

  localparam int BYTE_W = cnt_width(FRAME_BYTES);
  localparam int HIT_W  = cnt_width(LOCK_COUNT);
  localparam int MISS_W = cnt_width(LOSS_COUNT);

  localparam logic [HIT_W-1:0]  HIT_TGT  = HIT_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0] MISS_TGT = MISS_W'(LOSS_COUNT);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  sync_state_e       r_state;
  logic [7:0]        r_sr;
  logic [HIT_W-1:0]  r_hit_cnt;
  logic [MISS_W-1:0] r_miss_cnt;
  logic [7:0]        r_miss_total;
  logic              r_locked;
  logic [7:0]        r_byte_p1;
  logic              r_vld_p1;
  logic              r_fs_p1;

  logic [7:0]        w_cand;
  logic              w_match;
  logic              w_hunt;
  logic              w_load;
  logic              w_adv;
  logic [BYTE_W-1:0] w_byte_cnt;
  logic              w_byte_done;
  logic              w_sync_slot;
  logic              w_check;
  logic              w_payload;
  logic [HIT_W-1:0]  w_hit_inc;
  logic [MISS_W-1:0] w_miss_inc;

  assign w_cand     = {r_sr[6:0], d_bb};
  assign w_match    = (w_cand == SYNC_WORD);
  assign w_hunt     = (r_state == ST_HUNT);
  assign w_load     = sample_en & w_hunt & w_match;
  assign w_adv      = sample_en & ~w_hunt;
  assign w_check    = w_byte_done & w_sync_slot;
  assign w_payload  = w_byte_done & ~w_sync_slot;
  assign w_hit_inc  = r_hit_cnt + 1'b1;
  assign w_miss_inc = r_miss_cnt + 1'b1;

  frame_counter #(
    .FRAME_BYTES (FRAME_BYTES),
    .BYTE_W      (BYTE_W)
  ) u_frame_counter (
    .clk         (clk),
    .rst         (rst),
    .i_adv       (w_adv),
    .i_load      (w_load),
    .o_byte_cnt  (w_byte_cnt),
    .o_byte_done (w_byte_done),
    .o_sync_slot (w_sync_slot)
  );

  // Stage p0 -> p1: state update and registered payload/strobe outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_HUNT;
      r_sr         <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_miss_total <= '0;
      r_locked     <= 1'b0;
      r_byte_p1    <= '0;
      r_vld_p1     <= 1'b0;
      r_fs_p1      <= 1'b0;
    end else begin
      r_vld_p1 <= 1'b0;
      r_fs_p1  <= 1'b0;
      if (sample_en) begin
        r_sr <= w_cand;
        case (r_state)
          ST_HUNT: begin
            if (w_match) begin
              r_hit_cnt  <= HIT_W'(1);
              r_miss_cnt <= '0;
              if (LOCK_COUNT == 1) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end else begin
                r_state <= ST_VERIFY;
              end
            end
          end
          ST_VERIFY: begin
            if (w_check) begin
              if (w_match) begin
                r_hit_cnt <= w_hit_inc;
                if (w_hit_inc == HIT_TGT) begin
                  r_state    <= ST_LOCKED;
                  r_locked   <= 1'b1;
                  r_miss_cnt <= '0;
                end
              end else begin
                r_state   <= ST_HUNT;
                r_hit_cnt <= '0;
              end
            end
          end
          ST_LOCKED: begin
            if (w_payload) begin
              r_byte_p1 <= w_cand;
              r_vld_p1  <= 1'b1;
              r_fs_p1   <= (w_byte_cnt == '0);
            end
            if (w_check) begin
              if (w_match) begin
                r_miss_cnt <= '0;
              end else begin
                r_miss_total <= sat_inc8(r_miss_total);
                if (w_miss_inc == MISS_TGT) begin
                  // Loss of sync: the hunt resumes on the next sample, not this bit.
                  r_state    <= ST_HUNT;
                  r_locked   <= 1'b0;
                  r_hit_cnt  <= '0;
                  r_miss_cnt <= '0;
                end else begin
                  r_miss_cnt <= w_miss_inc;
                end
              end
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign byte_out       = r_byte_p1;
  assign byte_valid     = r_vld_p1;
  assign frame_start    = r_fs_p1;
  assign locked         = r_locked;
  assign sync_state     = r_state;
  assign miss_cnt_total = r_miss_total;

endmodule
